// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared widths, slot states and write-back request type
package cpu_defs;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic              wen;
        logic [XLEN-1:0]   data;
        logic [31:0]       pc;
    } wb_req_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // A buffered result is a forwarding candidate only if it will really write raddr.
    function automatic logic slot_hit(input logic full, input wb_req_t e,
                                      input logic [REG_AW-1:0] raddr);
        return full && e.wen && (e.dest == raddr) && (raddr != '0);
    endfunction
endpackage

// File: rtl/wb_slot.sv
// rtl/wb_slot.sv - one-entry result buffer with valid/ready input and drain control
module wb_slot
    import cpu_defs::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_valid,
    output logic    o_ready,
    input  wb_req_t i_req,
    input  logic    i_drain,
    output logic    o_full,
    output wb_req_t o_entry
);
    slot_state_t r_state;
    slot_state_t w_state_next;
    wb_req_t     r_entry;
    logic        w_accept;

    // Draining frees the slot in the same cycle, allowing one result per cycle.
    assign o_ready  = (r_state == SLOT_EMPTY) || i_drain;
    assign w_accept = i_valid && o_ready;
    assign o_full   = (r_state == SLOT_FULL);
    assign o_entry  = r_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
            r_entry <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_entry <= i_req;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SLOT_EMPTY: if (w_accept) w_state_next = SLOT_FULL;
            SLOT_FULL:  if (i_drain && !w_accept) w_state_next = SLOT_EMPTY;
            default:    w_state_next = SLOT_EMPTY;
        endcase
    end
endmodule

// File: rtl/wb_writeback.sv
// rtl/wb_writeback.sv - oldest-first write-back of EXE/MEM results with forwarding and trace
module wb_writeback
    import cpu_defs::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              exe_valid,
    output logic              exe_ready,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wen,
    input  logic [XLEN-1:0]   exe_data,
    input  logic [31:0]       exe_pc,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wen,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [31:0]       mem_pc,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic              hit1,
    output logic              hit2,
    output logic [XLEN-1:0]   fwd1,
    output logic [XLEN-1:0]   fwd2,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [REG_AW-1:0] debug_wb_rf_wnum,
    output logic [XLEN-1:0]   debug_wb_rf_wdata
);
    wb_req_t w_exe_req, w_mem_req, w_exe_entry, w_mem_entry, w_wb;
    logic    w_exe_full, w_mem_full;
    logic    w_drain_exe, w_drain_mem, w_drain_any, w_wr;
    logic    w_exe_hit1, w_mem_hit1, w_exe_hit2, w_mem_hit2;
    logic    r_mem_older;

    assign w_exe_req = '{dest: exe_dest, wen: exe_wen, data: exe_data, pc: exe_pc};
    assign w_mem_req = '{dest: mem_dest, wen: mem_wen, data: mem_data, pc: mem_pc};

    wb_slot u_exe_slot (
        .clk(clk), .rst_n(resetn), .i_valid(exe_valid), .o_ready(exe_ready),
        .i_req(w_exe_req), .i_drain(w_drain_exe), .o_full(w_exe_full), .o_entry(w_exe_entry)
    );

    wb_slot u_mem_slot (
        .clk(clk), .rst_n(resetn), .i_valid(mem_valid), .o_ready(mem_ready),
        .i_req(w_mem_req), .i_drain(w_drain_mem), .o_full(w_mem_full), .o_entry(w_mem_entry)
    );

    // A lone full slot always drains; with both full the older one goes first.
    assign w_drain_mem = w_mem_full && (!w_exe_full || r_mem_older);
    assign w_drain_exe = w_exe_full && !w_drain_mem;
    assign w_drain_any = w_drain_exe || w_drain_mem;
    assign w_wb        = w_drain_mem ? w_mem_entry : w_exe_entry;
    assign w_wr        = w_drain_any && w_wb.wen && (w_wb.dest != '0);

    // Both full only after a drain+refill (refilled slot is youngest) or a same-edge fill (MEM older).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_older <= 1'b0;
        end else begin
            r_mem_older <= (w_exe_full && w_mem_full) ? w_drain_exe : 1'b1;
        end
    end

    assign rf_we             = w_wr;
    assign rf_waddr          = w_drain_any ? w_wb.dest : '0;
    assign rf_wdata          = w_drain_any ? w_wb.data : '0;
    assign debug_wb_pc       = w_drain_any ? w_wb.pc : '0;
    assign debug_wb_rf_we    = {4{w_wr}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    assign w_exe_hit1 = slot_hit(w_exe_full, w_exe_entry, raddr1);
    assign w_mem_hit1 = slot_hit(w_mem_full, w_mem_entry, raddr1);
    assign w_exe_hit2 = slot_hit(w_exe_full, w_exe_entry, raddr2);
    assign w_mem_hit2 = slot_hit(w_mem_full, w_mem_entry, raddr2);

    assign hit1 = w_exe_hit1 || w_mem_hit1;
    assign hit2 = w_exe_hit2 || w_mem_hit2;

    // On a double match the younger entry carries the newest value of the register.
    assign fwd1 = (w_exe_hit1 && w_mem_hit1) ? (r_mem_older ? w_exe_entry.data : w_mem_entry.data) :
                  w_exe_hit1 ? w_exe_entry.data :
                  w_mem_hit1 ? w_mem_entry.data : '0;
    assign fwd2 = (w_exe_hit2 && w_mem_hit2) ? (r_mem_older ? w_exe_entry.data : w_mem_entry.data) :
                  w_exe_hit2 ? w_exe_entry.data :
                  w_mem_hit2 ? w_mem_entry.data : '0;
endmodule

// File: tb/tb_wb_writeback.sv
// tb/tb_wb_writeback.sv - self-checking scoreboard bench for wb_writeback
module tb_wb_writeback;
    logic        clk = 1'b0;
    logic        resetn;
    logic        exe_valid, exe_ready, exe_wen, mem_valid, mem_ready, mem_wen;
    logic [4:0]  exe_dest, mem_dest, raddr1, raddr2;
    logic [31:0] exe_data, exe_pc, mem_data, mem_pc;
    logic        rf_we, hit1, hit2;
    logic [4:0]  rf_waddr, debug_wb_rf_wnum;
    logic [31:0] rf_wdata, fwd1, fwd2, debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_we;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic        wen;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] shadow [32];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_writes = 0;

    always #5 clk = ~clk;

    wb_writeback dut (
        .clk(clk), .resetn(resetn),
        .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_dest(exe_dest), .exe_wen(exe_wen),
        .exe_data(exe_data), .exe_pc(exe_pc),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_wen(mem_wen),
        .mem_data(mem_data), .mem_pc(mem_pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .raddr1(raddr1), .raddr2(raddr2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exe_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic drive_exe(input logic [4:0] d, input logic w, input logic [31:0] v, input logic [31:0] pc);
        exe_valid = 1'b1; exe_dest = d; exe_wen = w; exe_data = v; exe_pc = pc;
    endtask

    task automatic drive_mem(input logic [4:0] d, input logic w, input logic [31:0] v, input logic [31:0] pc);
        mem_valid = 1'b1; mem_dest = d; mem_wen = w; mem_data = v; mem_pc = pc;
    endtask

    // Retirements are checked in acceptance order; same-edge accepts queue MEM first.
    always @(negedge clk) begin
        if (resetn) begin
            if (debug_wb_pc != 32'h0) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_retire", {32'h0, debug_wb_pc}, 64'h0);
                end else begin
                    exp_t e;
                    logic ew;
                    e  = sb.pop_front();
                    ew = e.wen && (e.dest != 5'd0);
                    check_eq("retire_pc", {32'h0, debug_wb_pc}, {32'h0, e.pc});
                    check_eq("retire_we", {63'h0, rf_we}, {63'h0, ew});
                    check_eq("retire_dbg_we", {60'h0, debug_wb_rf_we}, {60'h0, {4{ew}}});
                    if (ew) begin
                        check_eq("retire_waddr", {59'h0, rf_waddr}, {59'h0, e.dest});
                        check_eq("retire_wdata", {32'h0, rf_wdata}, {32'h0, e.data});
                        check_eq("retire_dbg_wnum", {59'h0, debug_wb_rf_wnum}, {59'h0, e.dest});
                        check_eq("retire_dbg_wdata", {32'h0, debug_wb_rf_wdata}, {32'h0, e.data});
                    end
                end
            end else begin
                check_eq("idle_we", {63'h0, rf_we}, 64'h0);
            end
            if (rf_we) begin
                shadow[rf_waddr] = rf_wdata;
                n_writes++;
            end
            if (mem_valid && mem_ready) sb.push_back('{pc: mem_pc, dest: mem_dest, wen: mem_wen, data: mem_data});
            if (exe_valid && exe_ready) sb.push_back('{pc: exe_pc, dest: exe_dest, wen: exe_wen, data: exe_data});
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
        resetn = 1'b0;
        idle();
        exe_dest = 0; exe_wen = 0; exe_data = 0; exe_pc = 0;
        mem_dest = 0; mem_wen = 0; mem_data = 0; mem_pc = 0;
        raddr1 = 0; raddr2 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rf_we", {63'h0, rf_we}, 64'h0);
        check_eq("rst_waddr", {59'h0, rf_waddr}, 64'h0);
        check_eq("rst_wdata", {32'h0, rf_wdata}, 64'h0);
        check_eq("rst_dbg_pc", {32'h0, debug_wb_pc}, 64'h0);
        check_eq("rst_hits", {62'h0, hit1, hit2}, 64'h0);
        check_eq("rst_fwd", {fwd1, fwd2}, 64'h0);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("rel_ready", {62'h0, exe_ready, mem_ready}, 64'h3);

        // single EXE result, one-cycle latency
        tick(); drive_exe(5'd5, 1'b1, 32'h1234, 32'h100);
        tick(); idle();
        @(negedge clk);
        check_eq("single_we", {63'h0, rf_we}, 64'h1);
        check_eq("single_waddr", {59'h0, rf_waddr}, 64'd5);
        check_eq("single_wdata", {32'h0, rf_wdata}, 64'h1234);
        tick(); @(negedge clk);
        check_eq("single_done_pc", {32'h0, debug_wb_pc}, 64'h0);

        // same-edge arrival, same destination: MEM first then EXE
        tick(); drive_mem(5'd3, 1'b1, 32'hA, 32'h200); drive_exe(5'd3, 1'b1, 32'hB, 32'h204);
        tick(); idle();
        @(negedge clk);
        check_eq("same_c1_wdata", {32'h0, rf_wdata}, 64'hA);
        check_eq("same_c1_ready", {62'h0, exe_ready, mem_ready}, 64'h1);
        tick(); @(negedge clk);
        check_eq("same_c2_wdata", {32'h0, rf_wdata}, 64'hB);
        check_eq("same_c2_exe_ready", {63'h0, exe_ready}, 64'h1);
        tick(); @(negedge clk);
        check_eq("same_final_r3", {32'h0, shadow[3]}, 64'hB);

        // r0 destination and wen=0 retire without writing
        tick(); drive_exe(5'd0, 1'b1, 32'hFFFF, 32'h300);
        tick(); idle();
        @(negedge clk);
        check_eq("r0_we", {63'h0, rf_we}, 64'h0);
        check_eq("r0_pc", {32'h0, debug_wb_pc}, 64'h300);
        check_eq("r0_ready", {63'h0, exe_ready}, 64'h1);
        tick(); @(negedge clk);
        check_eq("r0_freed_pc", {32'h0, debug_wb_pc}, 64'h0);
        tick(); drive_exe(5'd9, 1'b0, 32'h55, 32'h310); raddr1 = 5'd9;
        tick(); idle();
        @(negedge clk);
        check_eq("nowen_we", {63'h0, rf_we}, 64'h0);
        check_eq("nowen_hit1", {63'h0, hit1}, 64'h0);
        check_eq("nowen_pc", {32'h0, debug_wb_pc}, 64'h310);

        // forwarding picks the younger of two matching entries
        tick(); raddr1 = 5'd7; raddr2 = 5'd0;
        drive_mem(5'd7, 1'b1, 32'h1, 32'h400); drive_exe(5'd7, 1'b1, 32'h2, 32'h404);
        tick(); idle();
        @(negedge clk);
        check_eq("fwd_hit1", {63'h0, hit1}, 64'h1);
        check_eq("fwd_fwd1", {32'h0, fwd1}, 64'h2);
        check_eq("fwd_hit2", {63'h0, hit2}, 64'h0);
        check_eq("fwd_fwd2", {32'h0, fwd2}, 64'h0);
        tick(); @(negedge clk);
        check_eq("fwd_c2_fwd1", {32'h0, fwd1}, 64'h2);
        tick(); @(negedge clk);
        check_eq("fwd_gone", {31'h0, hit1, fwd1}, 64'h0);

        // EXE ahead by one cycle, then EXE+MEM together: order X1, M1, X2
        tick(); drive_exe(5'd10, 1'b1, 32'h11, 32'h500);
        tick(); drive_exe(5'd10, 1'b1, 32'h22, 32'h504); drive_mem(5'd10, 1'b1, 32'h33, 32'h508);
        tick(); idle();
        repeat (4) tick();
        @(negedge clk);
        check_eq("order_r10", {32'h0, shadow[10]}, 64'h22);

        // throughput: EXE every cycle, MEM idle
        n_writes = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); drive_exe(5'(1 + i), 1'b1, 32'h700 + 32'(i), 32'h600 + 32'(4 * i));
            @(negedge clk);
            check_eq($sformatf("tput_ready_%0d", i), {63'h0, exe_ready}, 64'h1);
        end
        tick(); idle();
        repeat (2) tick();
        check_eq("tput_writes", 64'(n_writes), 64'd10);

        // reset asserted mid-burst discards everything
        raddr1 = 5'd20;
        for (int i = 0; i < 4; i++) begin
            tick();
            drive_mem(5'd20, 1'b1, 32'h900 + 32'(i), 32'h800 + 32'(8 * i));
            drive_exe(5'd20, 1'b1, 32'hA00 + 32'(i), 32'h804 + 32'(8 * i));
        end
        tick(); #2;
        resetn = 1'b0;
        idle();
        #1;
        check_eq("midrst_we", {63'h0, rf_we}, 64'h0);
        check_eq("midrst_pc", {32'h0, debug_wb_pc}, 64'h0);
        check_eq("midrst_hit", {31'h0, hit1, fwd1}, 64'h0);
        check_eq("midrst_wdata", {32'h0, rf_wdata}, 64'h0);
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("postrst_quiet_%0d", i), {31'h0, rf_we, debug_wb_pc}, 64'h0);
        end

        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
